// File: rtl/change_dispenser.sv
// Change dispenser: pays out a requested taka amount as 20/10/5 note pulses,
// largest note first, drawing on a local note inventory.
module change_dispenser #(
    parameter int unsigned PULSE_LEN = 4,
    parameter int unsigned GAP_LEN   = 4,
    parameter int unsigned INIT20    = 7,
    parameter int unsigned INIT10    = 7,
    parameter int unsigned INIT5     = 7
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] amount,
    input  logic       clear,
    input  logic       restock,
    input  logic [2:0] select,
    output logic       tk20_out,
    output logic       tk10_out,
    output logic       tk5_out,
    output logic       busy,
    output logic       done,
    output logic       fault,
    output logic [7:0] owed,
    output logic [7:0] paid,
    output logic [3:0] cnt20,
    output logic [3:0] cnt10,
    output logic [3:0] cnt5
);

    localparam int unsigned AW = 8;
    localparam int unsigned CW = 4;
    localparam int unsigned TW = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_PULSE_HI,
        S_PULSE_LO,
        S_DONE,
        S_FAULT
    } state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [2:0]      note_q, note_d;     // one-hot {20,10,5}
    logic [AW-1:0]   owed_d, paid_d;
    logic [CW-1:0]   cnt20_d, cnt10_d, cnt5_d;
    logic            start_prev, clear_prev, restock_prev;
    logic            start_edge, clear_edge, restock_edge;
    logic            tk20_d, tk10_d, tk5_d, busy_d, done_d, fault_d;

    assign start_edge   = start & ~start_prev;
    assign clear_edge   = clear & ~clear_prev;
    assign restock_edge = restock & ~restock_prev;

    // State, datapath and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            timer_q      <= '0;
            note_q       <= '0;
            owed         <= '0;
            paid         <= '0;
            cnt20        <= CW'(INIT20);
            cnt10        <= CW'(INIT10);
            cnt5         <= CW'(INIT5);
            start_prev   <= 1'b1;
            clear_prev   <= 1'b1;
            restock_prev <= 1'b1;
            tk20_out     <= 1'b0;
            tk10_out     <= 1'b0;
            tk5_out      <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            fault        <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            note_q       <= note_d;
            owed         <= owed_d;
            paid         <= paid_d;
            cnt20        <= cnt20_d;
            cnt10        <= cnt10_d;
            cnt5         <= cnt5_d;
            start_prev   <= start;
            clear_prev   <= clear;
            restock_prev <= restock;
            tk20_out     <= tk20_d;
            tk10_out     <= tk10_d;
            tk5_out      <= tk5_d;
            busy         <= busy_d;
            done         <= done_d;
            fault        <= fault_d;
        end
    end

    // Next state, datapath updates and output decode
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        note_d  = note_q;
        owed_d  = owed;
        paid_d  = paid;
        cnt20_d = cnt20;
        cnt10_d = cnt10;
        cnt5_d  = cnt5;

        case (state_q)
            S_IDLE: begin
                if (start_edge) begin
                    owed_d  = amount;
                    paid_d  = '0;
                    state_d = S_SELECT;
                end else if (restock_edge) begin
                    case (select)
                        3'b001: if (cnt5 != 4'd15) cnt5_d = cnt5 + 4'd1;
                        3'b010: if (cnt10 != 4'd15) cnt10_d = cnt10 + 4'd1;
                        3'b100: if (cnt20 != 4'd15) cnt20_d = cnt20 + 4'd1;
                        default: ;
                    endcase
                end
            end
            S_SELECT: begin
                timer_d = '0;
                if (owed >= 8'd20 && cnt20 != 4'd0) begin
                    note_d  = 3'b100;
                    cnt20_d = cnt20 - 4'd1;
                    owed_d  = owed - 8'd20;
                    paid_d  = paid + 8'd20;
                    state_d = S_PULSE_HI;
                end else if (owed >= 8'd10 && cnt10 != 4'd0) begin
                    note_d  = 3'b010;
                    cnt10_d = cnt10 - 4'd1;
                    owed_d  = owed - 8'd10;
                    paid_d  = paid + 8'd10;
                    state_d = S_PULSE_HI;
                end else if (owed >= 8'd5 && cnt5 != 4'd0) begin
                    note_d  = 3'b001;
                    cnt5_d  = cnt5 - 4'd1;
                    owed_d  = owed - 8'd5;
                    paid_d  = paid + 8'd5;
                    state_d = S_PULSE_HI;
                end else if (owed == 8'd0) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_FAULT;
                end
            end
            S_PULSE_HI: begin
                if (timer_q == TW'(PULSE_LEN - 1)) begin
                    timer_d = '0;
                    state_d = S_PULSE_LO;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_PULSE_LO: begin
                if (timer_q == TW'(GAP_LEN - 1)) begin
                    timer_d = '0;
                    state_d = S_SELECT;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_DONE: state_d = S_IDLE;
            S_FAULT: begin
                if (clear_edge) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs decoded from the next state so they register in step with it
        tk20_d  = (state_d == S_PULSE_HI) && note_d[2];
        tk10_d  = (state_d == S_PULSE_HI) && note_d[1];
        tk5_d   = (state_d == S_PULSE_HI) && note_d[0];
        busy_d  = (state_d == S_SELECT) || (state_d == S_PULSE_HI) || (state_d == S_PULSE_LO);
        done_d  = (state_d == S_DONE);
        fault_d = (state_d == S_FAULT);
    end

endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: directed vector table, corner sequences and
// randomized payouts/restocks against a greedy arithmetic reference model.
module tb_change_dispenser;

    localparam int unsigned P   = 4;
    localparam int unsigned G   = 4;
    localparam int unsigned PER = 1 + P + G;

    logic       clk = 1'b0;
    logic       reset, start, clear, restock;
    logic [7:0] amount;
    logic [2:0] select;
    logic       tk20_out, tk10_out, tk5_out, busy, done, fault;
    logic [7:0] owed, paid;
    logic [3:0] cnt20, cnt10, cnt5;

    int checks = 0;
    int errors = 0;
    int m20, m10, m5;

    typedef struct {
        bit do_rst;
        int amt;
        int e_paid;
        int e_owed;
        bit e_fault;
        int e20;
        int e10;
        int e5;
    } vec_t;

    vec_t tbl[9];

    always #5 clk = ~clk;

    change_dispenser #(
        .PULSE_LEN(P), .GAP_LEN(G), .INIT20(7), .INIT10(7), .INIT5(7)
    ) u_dut (
        .clk(clk), .reset(reset), .start(start), .amount(amount),
        .clear(clear), .restock(restock), .select(select),
        .tk20_out(tk20_out), .tk10_out(tk10_out), .tk5_out(tk5_out),
        .busy(busy), .done(done), .fault(fault),
        .owed(owed), .paid(paid),
        .cnt20(cnt20), .cnt10(cnt10), .cnt5(cnt5)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_counts(input string tag);
        check({tag, "_cnt20"}, int'(cnt20), m20);
        check({tag, "_cnt10"}, int'(cnt10), m10);
        check({tag, "_cnt5"},  int'(cnt5),  m5);
    endtask

    task automatic do_reset();
        reset = 1'b0; start = 1'b0; clear = 1'b0; restock = 1'b0;
        select = 3'b000; amount = 8'd0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        m20 = 7; m10 = 7; m5 = 7;
    endtask

    function automatic int sat_inc(input int v);
        return (v >= 15) ? 15 : v + 1;
    endfunction

    task automatic restock_edge(input logic [2:0] sel);
        select  = sel;
        restock = 1'b1;
        @(negedge clk);
        restock = 1'b0;
        if (sel == 3'b001) m5 = sat_inc(m5);
        else if (sel == 3'b010) m10 = sat_inc(m10);
        else if (sel == 3'b100) m20 = sat_inc(m20);
        check_counts("restock");
        @(negedge clk);
    endtask

    // Greedy model, then cycle-accurate expected waveform from note index arithmetic
    task automatic run_payout(input int amt, input bit rs_at_start, input bit rs_mid,
                              output bit flt);
        int notes[$];
        int o;
        int n;
        int i;
        int ph;
        int ev;
        int av;
        o = amt;
        forever begin
            if (o >= 20 && m20 > 0) begin notes.push_back(20); m20--; o -= 20; end
            else if (o >= 10 && m10 > 0) begin notes.push_back(10); m10--; o -= 10; end
            else if (o >= 5 && m5 > 0) begin notes.push_back(5); m5--; o -= 5; end
            else break;
        end
        n   = notes.size();
        flt = (o != 0);

        amount = 8'(amt);
        start  = 1'b1;
        if (rs_at_start) begin restock = 1'b1; select = 3'b001; end
        @(posedge clk);
        @(negedge clk);
        start   = 1'b0;
        restock = 1'b0;
        check("owed_load", int'(owed), amt);
        check("paid_load", int'(paid), 0);
        for (int t = 0; t <= int'(PER) * n + 2; t++) begin
            if (t > 0) @(negedge clk);
            ev = 0;
            if (t >= 1) begin
                i  = (t - 1) / int'(PER);
                ph = (t - 1) % int'(PER);
                if (i < n && ph < int'(P)) begin
                    if (notes[i] == 20) ev = 6'b100000;
                    else if (notes[i] == 10) ev = 6'b010000;
                    else ev = 6'b001000;
                end
            end
            if (t <= int'(PER) * n) ev |= 6'b000100;
            if (!flt && t == int'(PER) * n + 1) ev |= 6'b000010;
            if (flt && t >= int'(PER) * n + 1) ev |= 6'b000001;
            av = int'({tk20_out, tk10_out, tk5_out, busy, done, fault});
            check("outputs", av, ev);
            if (t == int'(PER) * n + 1) begin
                check("owed_end", int'(owed), o);
                check("paid_end", int'(paid), amt - o);
                check_counts("payout");
            end
            if (rs_mid && t == 2) begin restock = 1'b1; select = 3'b100; end
            if (rs_mid && t == 3) restock = 1'b0;
        end
        restock = 1'b0;
    endtask

    task automatic clear_fault(input int residue);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check("clear_fault", int'(fault), 0);
        check("clear_owed", int'(owed), residue);
        check("clear_busy", int'(busy), 0);
        @(negedge clk);
    endtask

    initial begin
        bit flt;
        int r;
        int amt;

        tbl[0] = '{1'b1,  35,  35, 0, 1'b0, 6, 6, 6};
        tbl[1] = '{1'b0,  37,  35, 2, 1'b1, 5, 5, 5};
        tbl[2] = '{1'b0,   0,   0, 0, 1'b0, 5, 5, 5};
        tbl[3] = '{1'b0, 100, 100, 0, 1'b0, 0, 5, 5};
        tbl[4] = '{1'b0,  40,  40, 0, 1'b0, 0, 1, 5};
        tbl[5] = '{1'b0,  15,  15, 0, 1'b0, 0, 0, 4};
        tbl[6] = '{1'b0,  25,  20, 5, 1'b1, 0, 0, 0};
        tbl[7] = '{1'b1, 140, 140, 0, 1'b0, 0, 7, 7};
        tbl[8] = '{1'b0,  40,  40, 0, 1'b0, 0, 3, 7};

        do_reset();
        check("rst_outputs", int'({tk20_out, tk10_out, tk5_out, busy, done, fault}), 0);
        check("rst_owed", int'(owed), 0);
        check("rst_paid", int'(paid), 0);
        check("rst_cnt", int'({cnt20, cnt10, cnt5}), 12'h777);

        for (int k = 0; k < 9; k++) begin
            if (tbl[k].do_rst) do_reset();
            run_payout(tbl[k].amt, 1'b0, 1'b0, flt);
            check("tbl_paid", int'(paid), tbl[k].e_paid);
            check("tbl_owed", int'(owed), tbl[k].e_owed);
            check("tbl_fault", int'(fault), int'(tbl[k].e_fault));
            check("tbl_cnt", int'({cnt20, cnt10, cnt5}),
                  (tbl[k].e20 << 8) | (tbl[k].e10 << 4) | tbl[k].e5);
            if (tbl[k].e_fault) begin
                amount = 8'd99;
                start  = 1'b1;
                @(negedge clk);
                start = 1'b0;
                @(negedge clk);
                check("fault_start_ignored", int'({busy, fault}), 2'b01);
                check("fault_owed_hold", int'(owed), tbl[k].e_owed);
                clear_fault(tbl[k].e_owed);
            end
        end

        do_reset();
        for (int k = 0; k < 9; k++) restock_edge(3'b100);
        check("restock_sat", int'(cnt20), 15);
        restock_edge(3'b011);
        restock_edge(3'b001);
        run_payout(35, 1'b1, 1'b0, flt);
        run_payout(35, 1'b0, 1'b1, flt);

        do_reset();
        for (int k = 0; k < 30; k++) begin
            r = int'($urandom_range(0, 2));
            if (r == 0) begin
                restock_edge(3'($urandom));
            end else begin
                amt = int'($urandom_range(0, 18)) * 5;
                if ($urandom_range(0, 3) == 0) amt += int'($urandom_range(1, 4));
                run_payout(amt, 1'b0, 1'b0, flt);
                if (flt) clear_fault(int'(owed));
            end
        end

        // Asynchronous reset in the middle of the second note pulse
        do_reset();
        amount = 8'd35;
        start  = 1'b1;
        @(posedge clk);
        repeat (12) @(negedge clk);
        check("mid_second_pulse", int'({tk20_out, tk10_out, tk5_out}), 3'b010);
        #2 reset = 1'b0;
        #1;
        check("async_rst_outputs", int'({tk20_out, tk10_out, tk5_out, busy, done, fault}), 0);
        check("async_rst_cnt", int'({cnt20, cnt10, cnt5}), 12'h777);
        check("async_rst_owed", int'(owed), 0);
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            check("held_start_idle", int'({tk20_out, tk10_out, tk5_out, busy, done}), 0);
        end
        start = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
